gpio_serializer: RTL and testbench

- Downstream consumer of the GPIO register block's 32-bit `gpio_out` bus.
- Shifts the parallel value out to an external serial-in/parallel-out shift-register chain (74HC595-style) on three pins: serial clock, data, latch.
- A new frame starts automatically whenever the parallel input differs from the last value latched externally, or when a refresh is requested.
- Gives the SoC many physical outputs from three pads.

---
 rtl/gpio_serializer.sv | 171 +++++++++++++++++
 tb/tb_gpio_serializer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_serializer.sv
// gpio_serializer
//   Shifts the GPIO block's parallel output word into an external
//   74HC595-style serial-in/parallel-out chain using three pads
//   (ser_clk, ser_data, ser_latch). A frame starts automatically whenever
//   gpio_in differs from the value last latched externally, or when a
//   refresh is requested. One frame is also forced after every reset
//   release so the chain leaves reset in a known state.
//
// Parameters
//   WIDTH     bits per frame
//   CLK_DIV   clk cycles per ser_clk half-period (1..255)
//   MSB_FIRST 1 = bit WIDTH-1 shifted first, 0 = bit 0 first
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   gpio_in    parallel value to send
//   refresh    one-cycle request to resend gpio_in even if unchanged
//   ser_clk    serial shift clock to the chain
//   ser_data   serial data, stable across each ser_clk rising edge
//   ser_latch  storage-register latch strobe
//   busy       high while a frame is in progress
//   frame_done one-cycle pulse on the last cycle of a frame
//
// Optional feature (macro GPIO_SER_READBACK_EN)
//   ser_din    serial output of the chain, sampled as ser_clk rises
//   rd_data    word captured from ser_din, updated at frame end

module gpio_serializer #(
    parameter int WIDTH     = 32,
    parameter int CLK_DIV   = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gpio_in,
    input  logic             refresh,
    output logic             ser_clk,
    output logic             ser_data,
    output logic             ser_latch,
    output logic             busy,
    output logic             frame_done
`ifdef GPIO_SER_READBACK_EN
    ,
    input  logic             ser_din,
    output logic [WIDTH-1:0] rd_data
`endif
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sent_q;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shreg;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] cnt;
    logic             init_pend;
    logic             start;
    logic             next_bit;

`ifdef GPIO_SER_READBACK_EN
    logic [WIDTH-1:0] capture;
`endif

    assign start    = (gpio_in != sent_q) || refresh || init_pend;
    assign next_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

    // ser_data is registered: the first bit is driven on the same edge that
    // enters SHIFT, and each following bit on the edge that drops ser_clk,
    // so the data is settled a full half-period before every rising edge.
    // shreg holds the bits still to be sent after the one on ser_data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sent_q     <= '0;
            shadow     <= '0;
            shreg      <= '0;
            div        <= '0;
            cnt        <= '0;
            init_pend  <= 1'b1;
            ser_clk    <= 1'b0;
            ser_data   <= 1'b0;
            ser_latch  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef GPIO_SER_READBACK_EN
            capture    <= '0;
            rd_data    <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shadow    <= gpio_in;
                        shreg     <= MSB_FIRST ? (gpio_in << 1) : (gpio_in >> 1);
                        ser_data  <= MSB_FIRST ? gpio_in[WIDTH-1] : gpio_in[0];
                        cnt       <= '0;
                        div       <= '0;
                        init_pend <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
`ifdef GPIO_SER_READBACK_EN
                        capture   <= '0;
`endif
                    end
                end

                SHIFT: begin
                    if (div == DIV_LAST) begin
                        div <= '0;
                        if (!ser_clk) begin
                            ser_clk <= 1'b1;
`ifdef GPIO_SER_READBACK_EN
                            // Sampled before the chain shifts on this rise.
                            capture <= MSB_FIRST
                                ? ((capture << 1) | WIDTH'(ser_din))
                                : ((capture >> 1) | (WIDTH'(ser_din) << (WIDTH - 1)));
`endif
                        end else begin
                            ser_clk <= 1'b0;
                            if (cnt == CNT_LAST) begin
                                state      <= LATCH;
                                ser_latch  <= 1'b1;
                                // A single-cycle latch phase is also its last cycle.
                                frame_done <= (CLK_DIV == 1);
                            end else begin
                                cnt      <= cnt + 1'b1;
                                ser_data <= next_bit;
                                shreg    <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                            end
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end

                LATCH: begin
                    if (div == DIV_LAST) begin
                        div       <= '0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        ser_latch <= 1'b0;
                        ser_data  <= 1'b0;
                        sent_q    <= shadow;
`ifdef GPIO_SER_READBACK_EN
                        rd_data   <= capture;
`endif
                    end else begin
                        div        <= div + 1'b1;
                        // Raise the pulse so it is visible during the final cycle.
                        frame_done <= (int'(div) == CLK_DIV - 2);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_serializer.sv
// tb_gpio_serializer
//   Directed bench for gpio_serializer (WIDTH=32, CLK_DIV=2, MSB_FIRST=1).
//   A behavioural 595 model (shift on ser_clk rise, latch on ser_latch rise)
//   reconstructs the transmitted word; frame timing is measured alongside.
//   Define GPIO_SER_READBACK_EN to also exercise the loop-back capture.

module tb_gpio_serializer;

    localparam int WIDTH   = 32;
    localparam int CLK_DIV = 2;
    localparam int FRAME_BUSY = WIDTH * 2 * CLK_DIV + CLK_DIV;

    logic              clk = 1'b0;
    logic              reset;
    logic [WIDTH-1:0]  gpio_in;
    logic              refresh;
    logic              ser_clk, ser_data, ser_latch, busy, frame_done;

`ifdef GPIO_SER_READBACK_EN
    logic              ser_din;
    logic [WIDTH-1:0]  rd_data;
    logic [WIDTH-1:0]  chain = '0;
    logic              load_chain = 1'b0;

    always @(posedge ser_clk or posedge load_chain) begin
        if (load_chain) chain <= 32'h1234_5678;
        else            chain <= {chain[WIDTH-2:0], ser_data};
    end
    assign ser_din = chain[WIDTH-1];
`endif

    gpio_serializer #(
        .WIDTH    (WIDTH),
        .CLK_DIV  (CLK_DIV),
        .MSB_FIRST(1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .gpio_in   (gpio_in),
        .refresh   (refresh),
        .ser_clk   (ser_clk),
        .ser_data  (ser_data),
        .ser_latch (ser_latch),
        .busy      (busy),
        .frame_done(frame_done)
`ifdef GPIO_SER_READBACK_EN
        ,
        .ser_din   (ser_din),
        .rd_data   (rd_data)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- monitor / 595 model ----------------
    logic             clr = 1'b0;
    logic             prev_sclk = 1'b0, prev_latch = 1'b0, prev_busy = 1'b0;
    logic [WIDTH-1:0] rx = '0;
    logic [WIDTH-1:0] storage = '0;
    int               cyc = 0, t0 = 0, lat = 0;
    logic             got_first = 1'b1;
    int               rises = 0, busy_cyc = 0, fd_cnt = 0, latch_cyc = 0, frames = 0;

    always @(negedge clk) begin
        cyc        <= cyc + 1;
        prev_sclk  <= ser_clk;
        prev_latch <= ser_latch;
        prev_busy  <= busy;
        if (ser_clk && !prev_sclk)     rx      <= {rx[WIDTH-2:0], ser_data};
        if (ser_latch && !prev_latch)  storage <= rx;
        if (clr) begin
            rises     <= 0;
            busy_cyc  <= 0;
            fd_cnt    <= 0;
            latch_cyc <= 0;
            frames    <= 0;
        end else begin
            if (ser_clk && !prev_sclk) begin
                rises <= rises + 1;
                if (!got_first) begin
                    lat       <= cyc - t0;
                    got_first <= 1'b1;
                end
            end
            if (busy && !prev_busy) begin
                frames    <= frames + 1;
                t0        <= cyc;
                got_first <= 1'b0;
            end
            if (busy)       busy_cyc  <= busy_cyc + 1;
            if (frame_done) fd_cnt    <= fd_cnt + 1;
            if (ser_latch)  latch_cyc <= latch_cyc + 1;
        end
    end

    // ---------------- checking helpers ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        clr = 1'b1;
        @(negedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check_frames(input string tag, input int nf, input logic [31:0] word);
        chk({tag, " frames"},  frames,    nf);
        chk({tag, " rises"},   rises,     nf * WIDTH);
        chk({tag, " busy"},    busy_cyc,  nf * FRAME_BUSY);
        chk({tag, " done"},    fd_cnt,    nf);
        chk({tag, " latch"},   latch_cyc, nf * CLK_DIV);
        chk({tag, " word"},    storage,   word);
    endtask

    typedef struct {
        logic [31:0] gpio;
        logic        refresh;
        int          frames;
        logic [31:0] latched;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{32'hA5A5_0001, 1'b0, 1, 32'hA5A5_0001};
        vecs[1] = '{32'h0000_00FF, 1'b0, 1, 32'h0000_00FF};
        vecs[2] = '{32'h0000_00FF, 1'b1, 1, 32'h0000_00FF};  // refresh resend
        vecs[3] = '{32'h0000_00FF, 1'b0, 0, 32'h0000_00FF};  // unchanged: no frame
        vecs[4] = '{32'hFFFF_FFFF, 1'b0, 1, 32'hFFFF_FFFF};
        vecs[5] = '{32'h8000_0000, 1'b0, 1, 32'h8000_0000};
        vecs[6] = '{32'h0000_0000, 1'b0, 1, 32'h0000_0000};

        reset   = 1'b0;
        gpio_in = '0;
        refresh = 1'b0;

        // ---- reset state ----
        wait_cycles(3);
        chk("reset outputs", {27'd0, ser_clk, ser_data, ser_latch, busy, frame_done}, 32'd0);
        clear_mon();
        reset = 1'b1;

        // ---- init frame after reset release, gpio_in = 0 ----
        wait_cycles(FRAME_BUSY + 20);
        check_frames("init", 1, 32'h0);
        chk("init first-rise latency", lat, CLK_DIV);

        // ---- table-driven frames ----
        for (int i = 0; i < 7; i++) begin
            clear_mon();
            @(posedge clk); #1;
            gpio_in = vecs[i].gpio;
            refresh = vecs[i].refresh;
            @(posedge clk); #1;
            refresh = 1'b0;
            wait_cycles(FRAME_BUSY + 20);
            check_frames($sformatf("vec%0d", i), vecs[i].frames, vecs[i].latched);
            chk($sformatf("vec%0d latency", i), lat, CLK_DIV);
        end

        // ---- mid-frame changes 1 -> 2 -> 3 ----
        begin
            int  k;
            logic seen;
            clear_mon();
            @(posedge clk); #1; gpio_in = 32'h1;
            repeat (20) @(posedge clk); #1; gpio_in = 32'h2;
            repeat (20) @(posedge clk); #1; gpio_in = 32'h3;
            seen = 1'b0;
            for (k = 0; k < 400; k++) begin
                @(negedge clk); #1;
                if (busy) seen = 1'b1;
                else if (seen) break;
            end
            chk("mid busy fall seen", {31'd0, (k < 400) ? 1'b1 : 1'b0}, 32'd1);
            chk("mid first word", storage, 32'h1);
            wait_cycles(1);
            chk("mid restart after one idle", {31'd0, busy}, 32'd1);
            wait_cycles(FRAME_BUSY + 20);
            check_frames("mid", 2, 32'h3);
        end

        // ---- refresh; second refresh during the frame is dropped ----
        @(posedge clk); #1; gpio_in = 32'h0000_00FF;
        wait_cycles(FRAME_BUSY + 20);
        clear_mon();
        @(posedge clk); #1; refresh = 1'b1;
        @(posedge clk); #1; refresh = 1'b0;
        repeat (10) @(posedge clk); #1; refresh = 1'b1;
        @(posedge clk); #1; refresh = 1'b0;
        wait_cycles(2 * FRAME_BUSY + 20);
        check_frames("refresh", 1, 32'h0000_00FF);

        // ---- reset during bit 10 ----
        begin
            int k;
            clear_mon();
            @(posedge clk); #1; gpio_in = 32'hDEAD_BEEF;
            for (k = 0; k < 300; k++) begin
                @(negedge clk); #1;
                if (rises == 10) break;
            end
            chk("reset wait bit10", {31'd0, (k < 300) ? 1'b1 : 1'b0}, 32'd1);
            #2 reset = 1'b0;
            #1;
            chk("async reset outputs", {27'd0, ser_clk, ser_data, ser_latch, busy, frame_done}, 32'd0);
            clear_mon();
            reset = 1'b1;
            wait_cycles(FRAME_BUSY + 20);
            check_frames("post-reset", 1, 32'hDEAD_BEEF);
        end

`ifdef GPIO_SER_READBACK_EN
        // ---- loop-back capture ----
        load_chain = 1'b1;
        #1 load_chain = 1'b0;
        clear_mon();
        @(posedge clk); #1; gpio_in = 32'h0F0F_0F0F;
        wait_cycles(FRAME_BUSY + 20);
        check_frames("readback", 1, 32'h0F0F_0F0F);
        chk("readback rd_data", rd_data, 32'h1234_5678);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
